// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling and framing-error detection.
// Received bytes appear with a one-cycle o_valid pulse and stay stable until the next byte.
module uart_rx #(
    parameter int CLKS_PER_BITS = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_bit,
    output logic [7:0] o_data_byte,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       rx_busy
);

    localparam int HALF_BIT = (CLKS_PER_BITS - 1) / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;
    logic             busy_reg, busy_next;
    logic             rx_meta_reg, rx_s_reg;
    logic             shift_en;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= i_rx_bit;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Each shift bit loads only when the current index points at it.
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
        assign shift_next[gi] = (shift_en && idx_reg == 4'(gi)) ? rx_s_reg : shift_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        busy_next  = busy_reg;
        shift_en   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                idx_next  = '0;
                busy_next = 1'b0;
                if (!rx_s_reg) begin
                    state_next = START;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    if (!rx_s_reg) begin
                        cnt_next   = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    if (idx_reg == 4'd7) begin
                        idx_next   = '0;
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves time to catch an immediately following start bit.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_data_byte = data_reg;
    assign o_valid     = valid_reg;
    assign o_frame_err = err_reg;
    assign rx_busy     = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner cases, a vector table and random frames
// checked against a byte-level model of what the receiver must report.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_rx_bit;
    logic [7:0] o_data_byte;
    logic       o_valid;
    logic       o_frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BITS(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_bit    (i_rx_bit),
        .o_data_byte (o_data_byte),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
        bit         busy;
        bit         both;
    } ev_t;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         per;
        int         gap;
        bit         exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  got[$];
    exp_t exp_q[$];
    ev_t  mon_ev;
    logic busy_prev = 1'b0;
    int   busy_rise = 0;
    int   busy_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log of every output pulse, plus busy edge timestamps.
    always @(negedge clk) begin
        busy_prev <= rx_busy;
        if (rx_busy && !busy_prev) busy_rise <= cyc;
        if (!rx_busy && busy_prev) busy_fall <= cyc;
        if (rst_n && (o_valid || o_frame_err)) begin
            mon_ev.err  = o_frame_err;
            mon_ev.data = o_data_byte;
            mon_ev.cyc  = cyc;
            mon_ev.busy = rx_busy;
            mon_ev.both = o_valid && o_frame_err;
            got.push_back(mon_ev);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        i_rx_bit = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit k starts at cycle floor(k*per/100); per=1600 is nominal, 1632 is a 2% slow line.
    // Leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int per);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            i_rx_bit = bits[k];
            repeat (((k + 1) * per) / 100 - (k * per) / 100) @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_from(input int base, input string tag);
        check({tag, "_count"}, got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got.size()) begin
                $display("%s[%0d]: %s data=0x%02h (expect %s 0x%02h) cyc=%0d", tag, i,
                         got[base+i].err ? "frame_err" : "valid", got[base+i].data,
                         exp_q[i].err ? "frame_err" : "valid", exp_q[i].data, got[base+i].cyc);
                check({tag, "_kind"}, got[base+i].err, exp_q[i].err);
                check({tag, "_data"}, got[base+i].data, exp_q[i].data);
                check({tag, "_excl"}, got[base+i].both, 1'b0);
            end
        end
        exp_q.delete();
    endtask

    vec_t       tbl[10];
    int         base;
    int         t0;
    int         lat;
    logic [7:0] last_good;
    exp_t       e;

    initial begin
        tbl[0] = '{8'h00, 1'b1, 1600, 0,  1'b0, 8'h00};
        tbl[1] = '{8'hFF, 1'b1, 1600, 0,  1'b0, 8'hFF};
        tbl[2] = '{8'h3C, 1'b1, 1600, 0,  1'b0, 8'h3C};
        tbl[3] = '{8'h81, 1'b1, 1600, 12, 1'b0, 8'h81};
        tbl[4] = '{8'h96, 1'b1, 1632, 10, 1'b0, 8'h96};
        tbl[5] = '{8'h69, 1'b1, 1568, 10, 1'b0, 8'h69};
        tbl[6] = '{8'hC0, 1'b0, 1600, 12, 1'b1, 8'h69};
        tbl[7] = '{8'h01, 1'b1, 1600, 5,  1'b0, 8'h01};
        tbl[8] = '{8'h80, 1'b1, 1632, 0,  1'b0, 8'h80};
        tbl[9] = '{8'h7F, 1'b1, 1568, 8,  1'b0, 8'h7F};

        rst_n    = 1'b0;
        i_rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", o_data_byte, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ferr", o_frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Single 0xA5 frame: latency window and busy release one cycle after o_valid.
        base = got.size();
        t0   = cyc;
        send_frame(8'hA5, 1'b1, 1600);
        idle(20);
        check("a5_count", got.size() - base, 1);
        if (got.size() > base) begin
            lat = got[base].cyc - t0;
            $display("a5: data=0x%02h latency=%0d", got[base].data, lat);
            check("a5_latency_in_window", (lat >= 150 && lat <= 158), 1'b1);
            check("a5_data", got[base].data, 8'hA5);
            check("a5_no_ferr", got[base].err, 1'b0);
            check("a5_busy_at_valid", got[base].busy, 1'b1);
            check("a5_busy_fall", busy_fall, got[base].cyc + 1);
        end
        last_good = 8'hA5;

        // Three-cycle low glitch on an idle line.
        base = got.size();
        t0   = cyc;
        i_rx_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        $display("glitch: busy rise=%0d fall=%0d (t0=%0d)", busy_rise, busy_fall, t0);
        check("glitch_no_pulse", got.size() - base, 0);
        check("glitch_busy_rose", busy_rise >= t0, 1'b1);
        check("glitch_busy_fell", busy_fall > busy_rise, 1'b1);
        check("glitch_busy_short", busy_fall - t0 <= HALF + 4, 1'b1);
        check("glitch_busy_now", rx_busy, 1'b0);

        // Vector table, back-to-back loopback bytes first.
        base = got.size();
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].per);
            idle(tbl[i].gap);
            e.err  = tbl[i].exp_err;
            e.data = tbl[i].exp_byte;
            exp_q.push_back(e);
        end
        idle(40);
        compare_from(base, "table");
        last_good = 8'h7F;

        // Break: bad stop, line held low 40 more cycles, then a good 0x12.
        base = got.size();
        send_frame(8'h55, 1'b0, 1600);
        repeat (40) @(posedge clk);
        #1;
        check("break_single_err", got.size() - base, 1);
        check("break_busy_low_line", rx_busy, 1'b1);
        idle(10);
        send_frame(8'h12, 1'b1, 1600);
        idle(30);
        e.err = 1'b1; e.data = last_good; exp_q.push_back(e);
        e.err = 1'b0; e.data = 8'h12;     exp_q.push_back(e);
        compare_from(base, "break");
        last_good = 8'h12;

        // Reset mid-frame after four data bits of 0xC3, then 0x7E.
        base = got.size();
        i_rx_bit = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            i_rx_bit = (k < 2);
            repeat (CPB) @(posedge clk);
            #1;
        end
        rst_n    = 1'b0;
        i_rx_bit = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_rst_data", o_data_byte, 8'h00);
        check("abort_rst_valid", o_valid, 1'b0);
        check("abort_rst_ferr", o_frame_err, 1'b0);
        check("abort_rst_busy", rx_busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h7E, 1'b1, 1600);
        idle(30);
        e.err = 1'b0; e.data = 8'h7E; exp_q.push_back(e);
        compare_from(base, "abort");
        last_good = 8'h7E;

        // Random frames with +/-2% line rate, random gaps and occasional bad stop bits.
        base = got.size();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            bit         stop;
            int         per;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            per  = $urandom_range(1568, 1632);
            gap  = $urandom_range(0, 12);
            if (!stop) gap = gap + 8;
            send_frame(d, stop, per);
            idle(gap);
            if (stop) begin
                e.err = 1'b0; e.data = d; last_good = d;
            end else begin
                e.err = 1'b1; e.data = last_good;
            end
            exp_q.push_back(e);
        end
        idle(40);
        compare_from(base, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
